// File: rtl/fpu_seq_ctrl.sv
// fpu_seq_ctrl: execute-stage sequencer for a multi-cycle FP arithmetic core.
// Optional build macro: FPU_FFLAGS_EN (accrued exception flags).
//
// Ports:
//   clk, reset          clock; asynchronous active-high reset
//   FPUStart            decoded FP op present in E stage
//   FPUControl[2:0]     000 FADD, 001 FSUB, 010 FMUL, 011 FDIV, 1xx reserved
//   SrcAE, SrcBE        operands (XLEN)
//   RdE[4:0]            destination FP register
//   FlushE              squash E-stage instruction and any in-flight op
//   CoreStart           1-cycle issue pulse to the arithmetic core
//   CoreOp, CoreA/B     latched op and operands, held for the whole op
//   CoreDone            core result valid (1 cycle)
//   CoreResult          core result, valid with CoreDone
//   StallFPU            hold F/D/E stages
//   FPUResultValid      1-cycle writeback strobe
//   FPUResult, FPURd    result and destination, valid with the strobe
//   FPUTimeout          sticky watchdog-expiry flag, cleared by reset only
//   FPU_FFLAGS_EN only:
//   CoreFlags[4:0]      NV,DZ,OF,UF,NX from the core, valid with CoreDone
//   FFlagsClr           clear accrued flags
//   FFlags[4:0]         accrued flags of committed ops

module fpu_seq_ctrl #(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 7
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            FPUStart,
    input  logic [2:0]      FPUControl,
    input  logic [XLEN-1:0] SrcAE,
    input  logic [XLEN-1:0] SrcBE,
    input  logic [4:0]      RdE,
    input  logic            FlushE,
    output logic            CoreStart,
    output logic [2:0]      CoreOp,
    output logic [XLEN-1:0] CoreA,
    output logic [XLEN-1:0] CoreB,
    input  logic            CoreDone,
    input  logic [XLEN-1:0] CoreResult,
    output logic            StallFPU,
    output logic            FPUResultValid,
    output logic [XLEN-1:0] FPUResult,
    output logic [4:0]      FPURd,
    output logic            FPUTimeout
`ifdef FPU_FFLAGS_EN
    ,
    input  logic [4:0]      CoreFlags,
    input  logic            FFlagsClr,
    output logic [4:0]      FFlags
`endif
);

    if (TIMEOUT < 2 || (2 ** CNT_W) <= TIMEOUT) begin : g_param_bad
        $error("fpu_seq_ctrl: need TIMEOUT >= 2 and 2**CNT_W > TIMEOUT");
    end

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DRAIN
    } state_t;

    state_t state;
    state_t state_nx;

    logic [CNT_W-1:0] cnt;
    logic [4:0]       rd_q;
    logic             accept;
    logic             commit;
    logic             expire;
    logic             at_limit;

    // cnt holds the number of cycles elapsed since the CoreStart cycle.
    // Expiring one count early makes FPUTimeout visible exactly TIMEOUT
    // cycles after CoreStart; a CoreDone in that last cycle still wins.
    assign at_limit = (cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        CoreStart = 1'b0;
        StallFPU  = 1'b0;
        accept    = 1'b0;
        commit    = 1'b0;
        expire    = 1'b0;
        unique case (state)
            IDLE: begin
                // Reserved encodings and squashed starts never stall.
                if (FPUStart && !FlushE && !FPUControl[2]) begin
                    accept   = 1'b1;
                    StallFPU = 1'b1;
                    state_nx = ISSUE;
                end
            end
            ISSUE: begin
                // The issue pulse fires even when flushed; the core
                // must then be drained before returning to IDLE.
                CoreStart = 1'b1;
                StallFPU  = 1'b1;
                state_nx  = FlushE ? DRAIN : WAIT;
            end
            WAIT: begin
                StallFPU = 1'b1;
                if (CoreDone) begin
                    commit   = !FlushE;
                    state_nx = IDLE;
                end else if (at_limit) begin
                    expire   = 1'b1;
                    state_nx = IDLE;
                end else if (FlushE) begin
                    state_nx = DRAIN;
                end
            end
            DRAIN: begin
                StallFPU = 1'b1;
                if (CoreDone) begin
                    state_nx = IDLE;
                end else if (at_limit) begin
                    expire   = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Watchdog: zero in IDLE/ISSUE, counts every WAIT/DRAIN cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (state_nx == IDLE || state_nx == ISSUE) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Operand latches stay stable until the next accepted op.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            CoreOp <= '0;
            CoreA  <= '0;
            CoreB  <= '0;
            rd_q   <= '0;
        end else if (accept) begin
            CoreOp <= FPUControl;
            CoreA  <= SrcAE;
            CoreB  <= SrcBE;
            rd_q   <= RdE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            FPUResultValid <= 1'b0;
            FPUResult      <= '0;
            FPURd          <= '0;
        end else begin
            FPUResultValid <= commit;
            if (commit) begin
                FPUResult <= CoreResult;
                FPURd     <= rd_q;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            FPUTimeout <= 1'b0;
        end else if (expire) begin
            FPUTimeout <= 1'b1;
        end
    end

`ifdef FPU_FFLAGS_EN
    // Clear applies first so flags raised in the same cycle survive.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            FFlags <= '0;
        end else begin
            FFlags <= (FFlagsClr ? 5'b0 : FFlags)
                    | (commit ? CoreFlags : 5'b0);
        end
    end
`endif

endmodule

// File: tb/tb_fpu_seq_ctrl.sv
// tb_fpu_seq_ctrl: randomized and directed bench for fpu_seq_ctrl.
// Per-op expectations are derived from cycle arithmetic on each op.

module tb_fpu_seq_ctrl;

    localparam int XLEN = 32;
    localparam int TO   = 64;

    logic            clk = 1'b0;
    logic            reset;
    logic            FPUStart;
    logic [2:0]      FPUControl;
    logic [XLEN-1:0] SrcAE;
    logic [XLEN-1:0] SrcBE;
    logic [4:0]      RdE;
    logic            FlushE;
    logic            CoreStart;
    logic [2:0]      CoreOp;
    logic [XLEN-1:0] CoreA;
    logic [XLEN-1:0] CoreB;
    logic            CoreDone;
    logic [XLEN-1:0] CoreResult;
    logic            StallFPU;
    logic            FPUResultValid;
    logic [XLEN-1:0] FPUResult;
    logic [4:0]      FPURd;
    logic            FPUTimeout;
`ifdef FPU_FFLAGS_EN
    logic [4:0]      CoreFlags;
    logic            FFlagsClr;
    logic [4:0]      FFlags;
    logic [4:0]      ff_m;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    bit tmo_m = 1'b0;

    always #5 clk = ~clk;

    fpu_seq_ctrl #(
        .XLEN(XLEN),
        .TIMEOUT(TO),
        .CNT_W(7)
    ) dut (
        .clk(clk),
        .reset(reset),
        .FPUStart(FPUStart),
        .FPUControl(FPUControl),
        .SrcAE(SrcAE),
        .SrcBE(SrcBE),
        .RdE(RdE),
        .FlushE(FlushE),
        .CoreStart(CoreStart),
        .CoreOp(CoreOp),
        .CoreA(CoreA),
        .CoreB(CoreB),
        .CoreDone(CoreDone),
        .CoreResult(CoreResult),
        .StallFPU(StallFPU),
        .FPUResultValid(FPUResultValid),
        .FPUResult(FPUResult),
        .FPURd(FPURd),
        .FPUTimeout(FPUTimeout)
`ifdef FPU_FFLAGS_EN
        ,
        .CoreFlags(CoreFlags),
        .FFlagsClr(FFlagsClr),
        .FFlags(FFlags)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle_in();
        FPUStart   = 1'b0;
        FPUControl = 3'b000;
        SrcAE      = '0;
        SrcBE      = '0;
        RdE        = '0;
        FlushE     = 1'b0;
        CoreDone   = 1'b0;
        CoreResult = '0;
`ifdef FPU_FFLAGS_EN
        CoreFlags  = '0;
        FFlagsClr  = 1'b0;
`endif
    endtask

    // One instruction: start at cycle 0, core answers at cycle 1+lat
    // (never if hang), optional flush at cycle fl, optional flush
    // together with the start (sfl).
    task automatic run_op(input string tag, input logic [2:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input int lat,
                          input bit hang, input int fl, input bit sfl,
                          input logic [31:0] res, input logic [4:0] flg);
        int  d;
        int  win;
        int  e_stall;
        int  e_res;
        bit  acc;
        bit  tmo;
        bit  flushed;
        bit  tmo_was;
        int  n_st = 0;
        int  n_cs = 0;
        int  cs_cyc = -1;
        int  n_rv = 0;
        int  rv_cyc = -1;
        int  tmo_cyc = -1;
        int  bad_lat = 0;
        logic [31:0] rv_val = '0;
        logic [4:0]  rv_rd = '0;

        d       = 1 + lat;
        acc     = !op[2] && !sfl;
        tmo     = acc && (hang || d >= 1 + TO);
        flushed = acc && fl >= 1 && fl <= d;
        if (!acc) begin
            e_stall = 0;
            e_res   = 0;
        end else if (tmo) begin
            e_stall = TO + 1;
            e_res   = 0;
        end else begin
            e_stall = d + 1;
            e_res   = flushed ? 0 : 1;
        end
        win = hang ? TO + 2 : d + 2;
        if (tmo && win < TO + 2) win = TO + 2;
        tmo_was = tmo_m;

        for (int k = 0; k < win; k++) begin
            @(negedge clk);
            FPUStart   = (k == 0);
            FPUControl = op;
            SrcAE      = (k == 0) ? a : $urandom;
            SrcBE      = (k == 0) ? b : $urandom;
            RdE        = (k == 0) ? rd : 5'($urandom);
            FlushE     = (k == 0 && sfl) || (k == fl);
            CoreDone   = !hang && (k == d);
            CoreResult = (k == d) ? res : $urandom;
`ifdef FPU_FFLAGS_EN
            CoreFlags  = (k == d) ? flg : 5'($urandom);
`endif
            #1;
            if (StallFPU) n_st++;
            if (CoreStart) begin
                n_cs++;
                cs_cyc = k;
                if (CoreOp !== op || CoreA !== a || CoreB !== b)
                    bad_lat++;
            end
            if (acc && StallFPU && k >= 1 &&
                (CoreA !== a || CoreB !== b))
                bad_lat++;
            if (FPUResultValid) begin
                n_rv++;
                rv_cyc = k;
                rv_val = FPUResult;
                rv_rd  = FPURd;
            end
            if (FPUTimeout && tmo_cyc < 0) tmo_cyc = k;
        end
        FPUStart = 1'b0;
        FlushE   = 1'b0;
        CoreDone = 1'b0;

        if (tmo) tmo_m = 1'b1;
`ifdef FPU_FFLAGS_EN
        if (e_res == 1) ff_m = ff_m | flg;
`endif
        chk({tag, ".stall"}, n_st, e_stall);
        chk({tag, ".cstart"}, n_cs, 32'(acc));
        if (acc) chk({tag, ".cs_cyc"}, cs_cyc, 1);
        chk({tag, ".latch"}, bad_lat, 0);
        chk({tag, ".rvalid"}, n_rv, e_res);
        if (e_res == 1) begin
            chk({tag, ".rcyc"}, rv_cyc, d + 1);
            chk({tag, ".res"}, rv_val, res);
            chk({tag, ".rd"}, 32'(rv_rd), 32'(rd));
        end
        if (tmo && !tmo_was) chk({tag, ".tmo_cyc"}, tmo_cyc, TO + 1);
        chk({tag, ".tmo"}, 32'(FPUTimeout), 32'(tmo_m));
`ifdef FPU_FFLAGS_EN
        chk({tag, ".fflags"}, 32'(FFlags), 32'(ff_m));
`endif
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".cstart"}, 32'(CoreStart), 0);
        chk({tag, ".stall"}, 32'(StallFPU), 0);
        chk({tag, ".rvalid"}, 32'(FPUResultValid), 0);
        chk({tag, ".result"}, FPUResult, 0);
        chk({tag, ".rd"}, 32'(FPURd), 0);
        chk({tag, ".tmo"}, 32'(FPUTimeout), 0);
        chk({tag, ".op"}, 32'(CoreOp), 0);
        chk({tag, ".a"}, CoreA, 0);
        chk({tag, ".b"}, CoreB, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [2:0]  op;
        int          lat;
        int          fl;
        bit          sfl;

        idle_in();
        reset = 1'b1;
`ifdef FPU_FFLAGS_EN
        ff_m = '0;
`endif
        repeat (2) @(negedge clk);
        #1;
        chk_zero("reset");
        @(negedge clk);
        reset = 1'b0;

        run_op("fadd", 3'b000, 32'h3F80_0000, 32'h4000_0000, 5'd5,
               2, 1'b0, -1, 1'b0, 32'h4040_0000, 5'b00001);
        run_op("fdiv", 3'b011, 32'h4120_0000, 32'h4000_0000, 5'd17,
               20, 1'b0, -1, 1'b0, 32'h40A0_0000, 5'b00000);
        run_op("flush_wait", 3'b010, 32'h1234_5678, 32'h9ABC_DEF0,
               5'd9, 9, 1'b0, 5, 1'b0, 32'hDEAD_BEEF, 5'b10000);
        run_op("reserved", 3'b101, 32'h1, 32'h2, 5'd3,
               3, 1'b0, -1, 1'b0, 32'h5555_5555, 5'b11111);
        run_op("start_flush", 3'b001, 32'h3, 32'h4, 5'd4,
               3, 1'b0, -1, 1'b1, 32'h6666_6666, 5'b11111);
        run_op("flush_issue", 3'b001, 32'h7, 32'h8, 5'd6,
               4, 1'b0, 1, 1'b0, 32'h7777_7777, 5'b00100);
        run_op("flush_done", 3'b000, 32'h9, 32'hA, 5'd7,
               6, 1'b0, 7, 1'b0, 32'h8888_8888, 5'b00010);
        run_op("min_lat", 3'b010, 32'hB, 32'hC, 5'd31,
               1, 1'b0, -1, 1'b0, 32'h9999_9999, 5'b01000);

        for (int i = 0; i < 40; i++) begin
            op  = 3'($urandom_range(0, 7));
            lat = $urandom_range(1, 25);
            fl  = ($urandom_range(0, 3) == 0) ?
                  $urandom_range(1, lat + 1) : -1;
            sfl = ($urandom_range(0, 9) == 0);
            run_op($sformatf("rnd%0d", i), op, $urandom, $urandom,
                   5'($urandom), lat, 1'b0, fl, sfl, $urandom,
                   5'($urandom));
        end

        run_op("lat63", 3'b011, 32'h11, 32'h22, 5'd12,
               TO - 1, 1'b0, -1, 1'b0, 32'hCAFE_F00D, 5'b00001);

`ifdef FPU_FFLAGS_EN
        @(negedge clk);
        FFlagsClr = 1'b1;
        ff_m      = '0;
        @(negedge clk);
        FFlagsClr = 1'b0;
        run_op("fl_a", 3'b000, 32'h1, 32'h1, 5'd1, 2, 1'b0, -1, 1'b0,
               32'h2, 5'b00001);
        run_op("fl_b", 3'b010, 32'h1, 32'h1, 5'd2, 2, 1'b0, -1, 1'b0,
               32'h1, 5'b10000);
        chk("fflags_acc", 32'(FFlags), 32'h11);
        @(negedge clk);
        FFlagsClr = 1'b1;
        ff_m      = '0;
        @(negedge clk);
        FFlagsClr = 1'b0;
        #1;
        chk("fflags_clr", 32'(FFlags), 0);
`endif

        run_op("hang", 3'b011, 32'h33, 32'h44, 5'd13,
               0, 1'b1, -1, 1'b0, 32'h0, 5'b0);
        run_op("lat64", 3'b000, 32'h55, 32'h66, 5'd14,
               TO, 1'b0, -1, 1'b0, 32'h1111_2222, 5'b00001);
        run_op("after_tmo", 3'b001, 32'h77, 32'h88, 5'd15,
               4, 1'b0, -1, 1'b0, 32'h3333_4444, 5'b0);

        // Reset in the middle of a hung op.
        @(negedge clk);
        FPUStart   = 1'b1;
        FPUControl = 3'b010;
        SrcAE      = 32'hAAAA_0000;
        SrcBE      = 32'hBBBB_0000;
        RdE        = 5'd20;
        @(negedge clk);
        FPUStart = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        chk("mid.stall_before", 32'(StallFPU), 1);
        #1;
        reset = 1'b1;
        #1;
        chk_zero("mid_reset");
        @(negedge clk);
        reset = 1'b0;
        tmo_m = 1'b0;
`ifdef FPU_FFLAGS_EN
        ff_m = '0;
`endif
        run_op("post_reset", 3'b000, 32'h3F80_0000, 32'h3F80_0000,
               5'd8, 3, 1'b0, -1, 1'b0, 32'h4000_0000, 5'b00001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
